// File: rtl/mc_pwm_frame_gen_if.sv
// ---------------------------------------------------------------------------
// mc_pwm_frame_gen_if
// Bundles the modulator-facing command and the PWM-facing outputs of the
// frame generator.
//   Enable      : 1 = drive commanded pulse, 0 = neutral + State held at 0
//   Pulse       : requested pulse width in clock cycles (21 bits)
//   State       : frame index fed back to the modulator (5 bits)
//   PWM_Out     : servo/ESC PWM waveform
//   Frame_Start : one-cycle strobe in the first cycle of each frame
//   Clamp_Flag  : current frame's pulse was clamped or substituted
// master = modulator / bench side, slave = frame generator.
// ---------------------------------------------------------------------------
interface mc_pwm_frame_gen_if;
   logic        Enable;
   logic [20:0] Pulse;
   logic [4:0]  State;
   logic        PWM_Out;
   logic        Frame_Start;
   logic        Clamp_Flag;

   modport master (
      output Enable, Pulse,
      input  State, PWM_Out, Frame_Start, Clamp_Flag
   );

   modport slave (
      input  Enable, Pulse,
      output State, PWM_Out, Frame_Start, Clamp_Flag
   );
endinterface

// File: rtl/mc_pwm_frame_gen.sv
// ---------------------------------------------------------------------------
// mc_pwm_frame_gen
// Turns the modulator's pulse-width word into a fixed-period servo/ESC PWM
// frame and generates the frame index that closes the modulator loop.
//   CLK     : system clock
//   RESET_N : asynchronous active-low reset (released synchronously upstream)
//   bus     : slave side of mc_pwm_frame_gen_if (Enable/Pulse in,
//             State/PWM_Out/Frame_Start/Clamp_Flag out)
// Each frame's width is sampled in the last cycle of the previous frame,
// conditioned to the legal range, and held in a shadow register for the
// whole frame, so mid-frame Pulse changes never glitch the output.
// ---------------------------------------------------------------------------
module mc_pwm_frame_gen #(
   parameter int unsigned CLK_RATE      = 100000000,
   parameter int unsigned FRAME_CYCLES  = 2000000,
   parameter int unsigned NUM_STATES    = 24,
   parameter int unsigned MIN_PULSE     = 100000,
   parameter int unsigned MAX_PULSE     = 200000,
   parameter int unsigned NEUTRAL_PULSE = 150000
) (
   input  logic               CLK,
   input  logic               RESET_N,
   mc_pwm_frame_gen_if.slave  bus
);

   // Reject configurations the counter/State widths cannot represent, or
   // where the advance point would fall outside the frame.
   if (FRAME_CYCLES > (2**21) || FRAME_CYCLES <= MAX_PULSE ||
       NUM_STATES == 0 || NUM_STATES > 32 || CLK_RATE == 0 ||
       MIN_PULSE > NEUTRAL_PULSE || NEUTRAL_PULSE > MAX_PULSE) begin : g_cfg_err
      $error("mc_pwm_frame_gen: illegal parameter set");
   end

   localparam logic [20:0] C_LAST    = 21'(FRAME_CYCLES - 1);
   localparam logic [20:0] C_MIN     = 21'(MIN_PULSE);
   localparam logic [20:0] C_MAX     = 21'(MAX_PULSE);
   localparam logic [20:0] C_NEUTRAL = 21'(NEUTRAL_PULSE);
   localparam logic [4:0]  C_ST_LAST = 5'(NUM_STATES - 1);

   logic        r_run;      // 0 only for the first edge after reset release
   logic [20:0] r_cnt;
   logic [20:0] r_shadow;
   logic        r_clamp;
   logic [4:0]  r_state;
   logic        r_pwm;
   logic        r_fs;

   logic [20:0] w_cnt_nxt;
   logic        w_sample;
   logic        w_adv;
   logic [20:0] w_cond_pulse;
   logic        w_cond_flag;
   logic [20:0] w_shadow_nxt;
   logic        w_clamp_nxt;
   logic [4:0]  w_state_nxt;

   // The register state right after reset already represents the cnt==0
   // position, but the outputs are still low. The first edge after release
   // therefore holds cnt at 0 and only launches the registered outputs, so
   // the first visible frame starts at cnt==0 with a full-width pulse.
   always_comb begin
      w_cnt_nxt = 21'd0;
      if (r_run && r_cnt != C_LAST)
         w_cnt_nxt = r_cnt + 21'd1;
   end

   assign w_sample = r_run && (r_cnt == C_LAST);
   assign w_adv    = r_run && (r_cnt == C_MAX);

   // Pulse conditioning, highest priority first.
   always_comb begin
      w_cond_pulse = bus.Pulse;
      w_cond_flag  = 1'b0;
      if (!bus.Enable) begin
         w_cond_pulse = C_NEUTRAL;
         w_cond_flag  = 1'b0;
      end else if (bus.Pulse == 21'd0) begin
         // modulator not yet initialised
         w_cond_pulse = C_NEUTRAL;
         w_cond_flag  = 1'b1;
      end else if (bus.Pulse < C_MIN) begin
         w_cond_pulse = C_MIN;
         w_cond_flag  = 1'b1;
      end else if (bus.Pulse > C_MAX) begin
         w_cond_pulse = C_MAX;
         w_cond_flag  = 1'b1;
      end
   end

   assign w_shadow_nxt = w_sample ? w_cond_pulse : r_shadow;
   assign w_clamp_nxt  = w_sample ? w_cond_flag  : r_clamp;

   // State moves at cnt==MAX_PULSE: the pulse window is closed for every
   // legal width, and the modulator has most of the frame to react.
   always_comb begin
      w_state_nxt = r_state;
      if (w_adv) begin
         if (!bus.Enable)
            w_state_nxt = 5'd0;
         else if (r_state == C_ST_LAST)
            w_state_nxt = 5'd0;
         else
            w_state_nxt = r_state + 5'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_run    <= 1'b0;
         r_cnt    <= 21'd0;
         r_shadow <= C_NEUTRAL;
         r_clamp  <= 1'b0;
         r_state  <= 5'd0;
         r_pwm    <= 1'b0;
         r_fs     <= 1'b0;
      end else begin
         r_run    <= 1'b1;
         r_cnt    <= w_cnt_nxt;
         r_shadow <= w_shadow_nxt;
         r_clamp  <= w_clamp_nxt;
         r_state  <= w_state_nxt;
         // Outputs are registered from next-state values so they line up
         // with the cycle in which r_cnt holds that position.
         r_pwm    <= (w_cnt_nxt < w_shadow_nxt);
         r_fs     <= (w_cnt_nxt == 21'd0);
      end
   end

   assign bus.State       = r_state;
   assign bus.PWM_Out     = r_pwm;
   assign bus.Frame_Start = r_fs;
   assign bus.Clamp_Flag  = r_clamp;

endmodule

// File: doc/mc_pwm_frame_gen.md
Name: mc_pwm_frame_gen

Overview:
- Downstream stage of the motor-controller pulse modulator. It consumes the 21-bit pulse-width word (in CLK cycles) and produces the 50 Hz servo/ESC PWM waveform.
- It also generates the 5-bit State frame index that is fed back to the modulator; this closes the power-duty loop across a 24-frame cycle.
- Each frame's pulse width is double-buffered in a shadow register, clamped to the legal 1–2 ms range, and applied glitch-free.

Parameters:
- CLK_RATE, 100000000, input clock frequency in Hz (informational; sizes the defaults below).
- FRAME_CYCLES, 2000000, PWM frame length in CLK cycles (20 ms at 100 MHz); must be ≤ 2^21.
- NUM_STATES, 24, frame-index modulus; State counts 0..NUM_STATES-1.
- MIN_PULSE, 100000, minimum pulse width in cycles (1 ms, forward).
- MAX_PULSE, 200000, maximum pulse width in cycles (2 ms, reverse).
- NEUTRAL_PULSE, 150000, neutral/off pulse width in cycles (1.5 ms).

Ports:
- CLK  input  1  system clock.
- RESET_N  input  1  asynchronous active-low reset.
- Enable  input  1  1 = drive the commanded pulse; 0 = force neutral and hold State at 0.
- Pulse  input  21  requested pulse width in CLK cycles, from the modulator.
- State  output  5  frame index fed back to the modulator.
- PWM_Out  output  1  servo/ESC PWM signal.
- Frame_Start  output  1  one-cycle strobe in the first cycle of each frame.
- Clamp_Flag  output  1  1 for the whole frame if that frame's pulse was clamped or substituted.

Behaviour:
- Reset (async assert, sync release): cnt=0, shadow=NEUTRAL_PULSE, State=0, PWM_Out=0, Frame_Start=0, Clamp_Flag=0. The first frame begins at cnt=0 after release.
- Frame counter cnt (21 bits): increments each CLK and wraps FRAME_CYCLES-1 -> 0. No other event alters it except reset.
- Sample point, the cycle where cnt==FRAME_CYCLES-1:
  - Pulse is sampled and conditioned.
  - On the same edge that takes cnt to 0, the result loads into shadow and Clamp_Flag.
- Conditioning, in priority order:
  - Enable==0 -> NEUTRAL_PULSE, flag 0.
  - Pulse==0 (uninitialised modulator) -> NEUTRAL_PULSE, flag 1.
  - Pulse<MIN_PULSE -> MIN_PULSE, flag 1.
  - Pulse>MAX_PULSE -> MAX_PULSE, flag 1.
  - Otherwise Pulse unchanged, flag 0.
- Pulse changes at any other cnt value have no effect on the current frame; there is no mid-frame update.
- PWM_Out: registered, computed from next-state values. It is 1 exactly in the cycles where cnt < shadow: shadow consecutive cycles starting with the cnt==0 cycle, then low until the frame ends. Output period is exactly FRAME_CYCLES.
- Frame_Start: registered, high exactly in the cycle where cnt==0.
- State advance point, the cycle where cnt==MAX_PULSE:
  - Enable==1: State <= (State==NUM_STATES-1) ? 0 : State+1.
  - Enable==0: State <= 0.
  - Advancing here guarantees the pulse window has closed. The modulator's 1-cycle registered latency is absorbed long before the next sample point.
- Arithmetic: all comparisons are unsigned over 21 bits. Pulse values ≥ 2^20 are legal inputs and simply clamp to MAX_PULSE.
- Enable: sampled only at the sample point and the advance point. Toggling it elsewhere produces no output change until the next such point.
- Reset mid-frame: PWM_Out drops low asynchronously, and a fresh frame begins after release. No partial pulse is completed.

Test Plan:
- Reset: hold RESET_N=0, then release with Enable=1 and Pulse=150000. PWM_Out high for exactly 150000 cycles from cnt=0. Rising-edge-to-rising-edge period is 2000000. Frame_Start is one cycle wide and coincides with the first high cycle. State=0 until cnt=200000, then 1.
- Clamp: Pulse=50000 -> next frame high 100000 cycles, Clamp_Flag=1. Pulse=250000 -> high 200000, flag=1. Pulse=0 -> high 150000, flag=1. Pulse=180000 -> high 180000, flag=0.
- Double buffering: change Pulse from 100000 to 200000 at cnt=50000. Current frame remains 100000 cycles high; the following frame is 200000 cycles high.
- State wrap (override FRAME_CYCLES=4000, MIN/NEUTRAL/MAX=100/150/200, Enable=1): State counts 0..23 across 24 frames, then returns to 0. Each step occurs at cnt=200.
- Enable low: deassert Enable with Pulse=100000. Next frame is high 150000 cycles, Clamp_Flag=0, and State is 0 and stays 0. Reassert Enable: the commanded pulse resumes from the following sample point.
- Reset mid-pulse: assert RESET_N=0 at cnt=70000 while PWM_Out=1. PWM_Out goes 0 immediately and State=0. After release, a full new frame starts at cnt=0.
